// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, field constants and xtime.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] GF_POLY  = 8'h1B;
    localparam logic [7:0] COEF_0E  = 8'h0E;
    localparam logic [7:0] COEF_0B  = 8'h0B;
    localparam logic [7:0] COEF_0D  = 8'h0D;
    localparam logic [7:0] COEF_09  = 8'h09;
    localparam int         NUM_COLS = 4;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_gf_mul.sv
// Products of one byte by the four InvMixColumns coefficients, from an xtime chain.
module inv_gf_mul
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] mul_09,
    output logic [7:0] mul_0b,
    output logic [7:0] mul_0d,
    output logic [7:0] mul_0e
);

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    // Successive doublings give 2a, 4a, 8a; each coefficient is an XOR of those.
    always_comb begin
        x2     = xtime(a);
        x4     = xtime(x2);
        x8     = xtime(x4);
        mul_09 = x8 ^ a;
        mul_0b = x8 ^ x2 ^ a;
        mul_0d = x8 ^ x4 ^ a;
        mul_0e = x8 ^ x4 ^ x2;
    end

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns over a 128-bit state, one column per cycle through a shared multiplier set.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// BUSY  | transforming column col_q in place, columns 0..3
// DONE  | result held on dataOut with out_valid=1 until out_ready
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] dataIn,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] dataOut,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t       state_q;
    state_t       state_d;
    logic [127:0] st_q;
    logic [1:0]   col_q;
    logic         load;
    logic         write_col;

    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [7:0]   a    [NUM_COLS];
    logic [7:0]   m09  [NUM_COLS];
    logic [7:0]   m0b  [NUM_COLS];
    logic [7:0]   m0d  [NUM_COLS];
    logic [7:0]   m0e  [NUM_COLS];
    logic [7:0]   b    [NUM_COLS];

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        write_col = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = enable ? BUSY : DONE;
                end
            end
            BUSY: begin
                write_col = 1'b1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the active column; a0 is the most significant byte.
    always_comb begin
        col_in = st_q[32*col_q +: 32];
        for (int i = 0; i < NUM_COLS; i++) begin
            a[i] = col_in[31-8*i -: 8];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COLS; g++) begin : g_mul
            inv_gf_mul u_mul (
                .a      (a[g]),
                .mul_09 (m09[g]),
                .mul_0b (m0b[g]),
                .mul_0d (m0d[g]),
                .mul_0e (m0e[g])
            );
        end
    endgenerate

    // Circulant combine: row i takes 0E at byte i, then 0B, 0D, 09 rotating right.
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            b[i] = m0e[i] ^ m0b[(i+1)%NUM_COLS] ^ m0d[(i+2)%NUM_COLS] ^ m09[(i+3)%NUM_COLS];
        end
        col_out = {b[0], b[1], b[2], b[3]};
    end

    // State register and column counter; the counter wraps 3->0 on the last BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            col_q <= 2'd0;
        end else if (load) begin
            st_q  <= dataIn;
            col_q <= 2'd0;
        end else if (write_col) begin
            st_q[32*col_q +: 32] <= col_out;
            col_q                <= col_q + 2'd1;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dataOut   = st_q;

endmodule
